// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and dump FSM state type for the register bank
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - dump stream interface between register bank and state viewer
interface regfile_param_if #(
    parameter int XLEN   = regfile_pkg::XLEN_DEF,
    parameter int ADDR_W = $clog2(regfile_pkg::DEPTH_DEF)
);

    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_idx;
    logic [XLEN-1:0]   dump_data;
    logic              dump_busy;
    logic              dump_done;

    modport master (
        input  dump_start, dump_ready,
        output dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

    modport slave (
        output dump_start, dump_ready,
        input  dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - serial dump FSM: walks every register over a valid/ready handshake
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] look_idx,
    input  logic [XLEN-1:0]   look_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dump_state_t state, state_n;
    logic        load;

    // Index the array one ahead so the next beat is ready on the accepting edge.
    assign look_idx   = (state == IDLE) ? '0 : dump_idx + 1'b1;
    assign dump_valid = (state == SEND);
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);

    // State register; reset aborts any dump in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Beat register only moves on start or acceptance, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_idx  <= '0;
            dump_data <= '0;
        end else if (load) begin
            dump_idx  <= look_idx;
            dump_data <= look_data;
        end
    end

    // Next-state and beat-load decode.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_n = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) state_n = DONE;
                    else                      load    = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register bank, 2R/1W with write-back mux and dump engine (option: REGFILE_WRITE_BYPASS_EN)
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stage_en,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic              wb_sel,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    regfile_param_if.master   dump
);

    logic [XLEN-1:0]   regs [DEPTH];
    logic [XLEN-1:0]   wdata;
    logic              wr_en;
    logic [XLEN-1:0]   rd1_next;
    logic [XLEN-1:0]   rd2_next;
    logic [ADDR_W-1:0] look_idx;
    logic [XLEN-1:0]   look_data;

    assign wdata = (wb_sel == WB_SEL_MEM) ? mem_rdata : alu_result;
    assign wr_en = stage_en & we & ((rd != '0) | (ZERO_REG == 0));

    // Register array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rd] <= wdata;
        end
    end

    // Read-port next values: optional same-cycle bypass, zero register forced last.
    always_comb begin
        rd1_next = regs[rs1];
        rd2_next = regs[rs2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && (rd == rs1)) rd1_next = wdata;
        if (wr_en && (rd == rs2)) rd2_next = wdata;
`else
`endif
        if ((ZERO_REG != 0) && (rs1 == '0)) rd1_next = '0;
        if ((ZERO_REG != 0) && (rs2 == '0)) rd2_next = '0;
    end

    // Registered read ports, held while the stage is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (stage_en) begin
            rdata1 <= rd1_next;
            rdata2 <= rd2_next;
        end
    end

    // Dump lookup sees the post-write value when a write lands on the same edge.
    always_comb begin
        look_data = regs[look_idx];
        if (wr_en && (rd == look_idx)) look_data = wdata;
        if ((ZERO_REG != 0) && (look_idx == '0)) look_data = '0;
    end

    regfile_dump_ctrl #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump.dump_start),
        .dump_ready (dump.dump_ready),
        .dump_valid (dump.dump_valid),
        .dump_idx   (dump.dump_idx),
        .dump_data  (dump.dump_data),
        .dump_busy  (dump.dump_busy),
        .dump_done  (dump.dump_done),
        .look_idx   (look_idx),
        .look_data  (look_data)
    );

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the datapath register bank.
- Two registered read ports and one write-back port, with the write-back mux (ALU result vs memory data) built in.
- Architectural zero register.
- A serial dump engine streams every register over a valid/ready handshake for the state viewer and testbench, replacing the 32 flat per-register output buses.

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers (power of two, at least 2).
- ADDR_W, $clog2(DEPTH), register index width (derived, not overridden).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- stage_en  in  1  high during the execute/write-back stage; gates reads and writes.
- rs1  in  ADDR_W  read index, port 1.
- rs2  in  ADDR_W  read index, port 2.
- rd  in  ADDR_W  write index.
- we  in  1  write enable.
- wb_sel  in  1  write-data select: 1 = mem_rdata, 0 = alu_result.
- alu_result  in  XLEN  ALU write-back data.
- mem_rdata  in  XLEN  memory write-back data.
- rdata1  out  XLEN  registered read data, port 1.
- rdata2  out  XLEN  registered read data, port 2.
- dump_start  in  1  pulse that starts a full dump.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  ADDR_W  index of the current beat.
- dump_data  out  XLEN  value of the current beat.
- dump_busy  out  1  dump engine not idle.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n low, async):
  - all registers 0;
  - rdata1, rdata2, dump_data, dump_idx = 0;
  - dump_valid, dump_busy, dump_done = 0;
  - FSM in IDLE.
- Write data: wdata = wb_sel ? mem_rdata : alu_result.
- Write: takes effect at the posedge where stage_en & we are both high and (rd != 0 or ZERO_REG = 0).
- Read:
  - at a posedge with stage_en high, rdataN <= reg[rsN];
  - latency 1 cycle;
  - rdataN holds its value while stage_en is low.
- Zero register: with ZERO_REG = 1, a read of index 0 returns 0 regardless of array contents.
- Read-during-write (rsN == rd in the same enabled cycle): rdataN returns the OLD value; see the optional feature.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: on dump_start, set dump_idx = 0, load dump_data = reg[0] (0 if zero-reg), set dump_valid = 1, go to SEND.
  - SEND: dump_data and dump_idx stay stable while dump_valid & !dump_ready, even if that register is written meanwhile.
  - SEND, on valid & ready with idx < DEPTH-1: idx increments and dump_data reloads from the live array (post-write value) the next cycle. Throughput is 1 beat/cycle with ready held high.
  - SEND, on valid & ready with idx == DEPTH-1: dump_valid = 0, go to DONE.
  - DONE: dump_done = 1 for exactly one cycle, then IDLE.
- dump_busy = 1 in SEND and DONE.
- dump_start is ignored while busy.
- The dump never blocks reads or writes.
- Reset mid-dump aborts the dump: FSM goes to IDLE and no dump_done pulse is issued.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in the same-cycle read/write case (stage_en & we, rsN == rd, rd writable), rdataN <= wdata, i.e. the new value.
- Not defined: rdataN <= old register value.
- Zero-register reads return 0 in both builds.

Decomposition:
- Package regfile_pkg:
  - dump FSM state enum (IDLE/SEND/DONE);
  - WB_SEL_ALU = 1'b0, WB_SEL_MEM = 1'b1;
  - default XLEN/DEPTH constants.
- One sub-module, regfile_dump_ctrl: the dump FSM, index counter and handshake. It takes the array read value through an index/data pair.

Test Plan:
- Reset then read: assert rst_n = 0 mid-cycle; outputs are 0 immediately. After release, read rs1 = 5, rs2 = 31 with stage_en = 1 -> rdata1 = rdata2 = 0 one cycle later.
- Write-back mux:
  - rd = 3, we = 1, wb_sel = 0, alu_result = 0x12345678 -> a later read of rs1 = 3 gives 0x12345678;
  - wb_sel = 1, mem_rdata = 0xCAFEBABE -> reads 0xCAFEBABE.
- Zero register and gating:
  - write 0xFFFFFFFF to rd = 0 -> rs1 = 0 reads 0;
  - write with stage_en = 0 to rd = 7 -> reg7 unchanged; rdata holds its prior value.
- Read-during-write: rs1 = rd = 9, old value 0x11, wdata 0x22 -> rdata1 = 0x11 without the macro, 0x22 with REGFILE_WRITE_BYPASS_EN.
- Dump with backpressure: load reg[i] = i*4, pulse dump_start, toggle dump_ready randomly -> exactly DEPTH beats, idx 0..DEPTH-1 in order, data = i*4 (idx 0 = 0), data stable while stalled, single dump_done pulse, second dump_start while busy ignored.
- Reset mid-dump: pull rst_n low at beat 10 -> dump_valid = 0 and dump_busy = 0 asynchronously, no dump_done. A new dump_start after release restarts at idx 0.
